// File: rtl/perf_sample_ctrl.sv
// Sampling controller for the performance counter bank: shares the bank's register
// port with the CSR file and streams {seq, counters} records to a memory writer.
module perf_sample_ctrl #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned SeqWidth    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                csr_req_i,
  input  logic [11:0]         csr_addr_i,
  input  logic                csr_we_i,
  input  logic [63:0]         csr_wdata_i,
  output logic [63:0]         csr_rdata_o,
  output logic [11:0]         pc_addr_o,
  output logic                pc_we_o,
  output logic [63:0]         pc_wdata_o,
  input  logic [63:0]         pc_rdata_i,
  input  logic                cfg_en_i,
  input  logic [31:0]         cfg_period_i,
  input  logic [63:0]         cfg_base_i,
  input  logic                irq_i,
  output logic                smp_valid_o,
  input  logic                smp_ready_i,
  output logic [63:0]         smp_addr_o,
  output logic [63:0]         smp_data_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic [SeqWidth-1:0] seq_o
);

  localparam int unsigned KW = (NumCounters > 1) ? $clog2(NumCounters) : 1;
  localparam logic [KW-1:0] KLast = KW'(NumCounters - 1);
  localparam logic [11:0] CntBase = 12'hB03;

  typedef enum logic [2:0] {IDLE, HDR, READ, SEND, DONE} state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [63:0]         base_q, base_d;
  logic [63:0]         data_q, data_d;
  logic [SeqWidth-1:0] seq_q, seq_d, seq_inc;
  logic                pending_q, pending_d;
  logic                overrun_q, overrun_d;
  logic                irq_q;
  logic [31:0]         timer_q, timer_d;
  logic                tick, trigger, timer_run;

  assign seq_inc = seq_q + SeqWidth'(1);

  // Timer: held at the period while disabled, ticks on the cycle it reads 1.
  assign timer_run = cfg_en_i && (cfg_period_i != '0);

  always_comb begin
    tick    = 1'b0;
    timer_d = timer_q;
    if (!timer_run) begin
      timer_d = cfg_period_i;
    end else if (timer_q <= 32'd1) begin
      tick    = (timer_q == 32'd1);
      timer_d = cfg_period_i;
    end else begin
      timer_d = timer_q - 32'd1;
    end
  end

  assign trigger = cfg_en_i & (tick | (irq_i & ~irq_q));

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    data_d    = data_q;
    seq_d     = seq_q;
    pending_d = pending_q;
    overrun_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          base_d  = cfg_base_i;
          state_d = HDR;
        end
      end
      HDR: begin
        if (smp_ready_i) begin
          k_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        if (!csr_req_i) begin
          data_d  = pc_rdata_i;
          state_d = SEND;
        end
      end
      SEND: begin
        if (smp_ready_i) begin
          if (k_q == KLast) begin
            state_d = DONE;
          end else begin
            k_d     = k_q + KW'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        seq_d   = seq_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // One trigger may queue behind a busy record; a second one is dropped.
    if (state_q == IDLE) begin
      pending_d = 1'b0;
    end else if (trigger) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end
    if (!cfg_en_i) pending_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      k_q       <= '0;
      base_q    <= '0;
      data_q    <= '0;
      seq_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      base_q    <= base_d;
      data_q    <= data_d;
      seq_q     <= seq_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      irq_q     <= irq_i;
      timer_q   <= timer_d;
    end
  end

  // Record stream outputs derive only from registered state, so they hold under stall.
  always_comb begin
    smp_valid_o = 1'b0;
    smp_addr_o  = '0;
    smp_data_o  = '0;
    case (state_q)
      HDR: begin
        smp_valid_o = 1'b1;
        smp_addr_o  = base_q;
        smp_data_o  = 64'(seq_inc);
      end
      SEND: begin
        smp_valid_o = 1'b1;
        smp_addr_o  = base_q + ((64'(k_q) + 64'd1) << 3);
        smp_data_o  = data_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_addr_o  = '0;
    pc_we_o    = 1'b0;
    pc_wdata_o = '0;
    if (csr_req_i) begin
      pc_addr_o  = csr_addr_i;
      pc_we_o    = csr_we_i;
      pc_wdata_o = csr_wdata_i;
    end else if (state_q == READ) begin
      pc_addr_o = CntBase + 12'(k_q);
    end
  end

  assign csr_rdata_o = pc_rdata_i;
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = overrun_q;
  assign seq_o       = seq_q;

endmodule

// File: tb/tb_perf_sample_ctrl.sv
// Directed bench for perf_sample_ctrl with a behavioural counter bank and record collector.
module tb_perf_sample_ctrl;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        csr_req, csr_we;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, csr_rdata;
  logic [11:0] pc_addr;
  logic        pc_we;
  logic [63:0] pc_wdata, pc_rdata;
  logic        cfg_en;
  logic [31:0] cfg_period;
  logic [63:0] cfg_base;
  logic        irq;
  logic        smp_valid, smp_ready;
  logic [63:0] smp_addr, smp_data;
  logic        busy, overrun;
  logic [31:0] seq;

  int errors = 0;
  int checks = 0;

  logic [63:0] ctr [6];
  logic [63:0] q_addr [$];
  logic [63:0] q_data [$];
  logic        stall_p = 1'b0;
  logic [63:0] stall_a, stall_d;

  perf_sample_ctrl #(.NumCounters(6), .SeqWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .csr_req_i(csr_req), .csr_addr_i(csr_addr), .csr_we_i(csr_we),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
    .pc_addr_o(pc_addr), .pc_we_o(pc_we), .pc_wdata_o(pc_wdata), .pc_rdata_i(pc_rdata),
    .cfg_en_i(cfg_en), .cfg_period_i(cfg_period), .cfg_base_i(cfg_base), .irq_i(irq),
    .smp_valid_o(smp_valid), .smp_ready_i(smp_ready), .smp_addr_o(smp_addr),
    .smp_data_o(smp_data), .busy_o(busy), .overrun_o(overrun), .seq_o(seq)
  );

  always #5 clk = ~clk;

  // Counter bank: counters at 0xB03..0xB08, a recognisable pattern elsewhere.
  always_comb begin
    pc_rdata = 64'hDEAD_0000_0000_0000 | 64'(pc_addr);
    if (pc_addr >= 12'hB03 && pc_addr <= 12'hB08) pc_rdata = ctr[3'(pc_addr - 12'hB03)];
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall_p) begin
      check("hold_valid", 64'(smp_valid), 64'd1);
      check("hold_addr", smp_addr, stall_a);
      check("hold_data", smp_data, stall_d);
    end
    if (rst_ni && smp_valid && smp_ready) begin
      q_addr.push_back(smp_addr);
      q_data.push_back(smp_data);
    end
    stall_p <= rst_ni && smp_valid && !smp_ready;
    stall_a <= smp_addr;
    stall_d <= smp_data;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic wait_busy(input int max, output int n);
    n = 0;
    while (!busy && n < max) begin
      step();
      n++;
    end
    check("wait_busy", 64'(busy), 64'd1);
  endtask

  task automatic run_record(input logic [63:0] stall_off, input int stall_len,
                            input logic [11:0] csr_trig, input int csr_len, output int dur);
    int sl = stall_len;
    int cl = csr_len;
    dur = 0;
    while (busy && dur < 100) begin
      dur++;
      if (sl > 0 && smp_valid && smp_addr == BASE + stall_off) begin
        smp_ready = 1'b0;
        sl--;
      end else begin
        smp_ready = 1'b1;
      end
      if (cl > 0 && (csr_req || pc_addr == csr_trig)) begin
        csr_req  = 1'b1;
        csr_addr = 12'hB04;
        csr_we   = 1'b0;
        cl--;
        #1;
        check("csr_pc_addr", 64'(pc_addr), 64'hB04);
        check("csr_rdata", csr_rdata, 64'd2);
        check("csr_pc_we", 64'(pc_we), 64'd0);
      end else begin
        csr_req = 1'b0;
      end
      step();
    end
    smp_ready = 1'b1;
    csr_req   = 1'b0;
    check("rec_end", 64'(busy), 64'd0);
  endtask

  task automatic check_record(input logic [63:0] seq_exp);
    check("rec_len", 64'(q_addr.size()), 64'd7);
    if (q_addr.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        check("rec_addr", q_addr[i], BASE + 64'(8 * i));
        check("rec_data", q_data[i], (i == 0) ? seq_exp : 64'(i));
      end
    end
  endtask

  initial begin
    int n, dur, cnt, rises;
    logic prev;
    logic bz [16];
    logic ov [16];

    rst_ni = 1'b0; csr_req = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    cfg_en = 1'b0; cfg_period = 32'd100; cfg_base = BASE; irq = 1'b0; smp_ready = 1'b1;
    for (int i = 0; i < 6; i++) ctr[i] = 64'(i + 1);
    #2;
    check("rst_valid", 64'(smp_valid), 64'd0);
    check("rst_addr", smp_addr, 64'd0);
    check("rst_data", smp_data, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_seq", 64'(seq), 64'd0);
    check("rst_pc_addr", 64'(pc_addr), 64'd0);
    check("rst_csr_rdata", csr_rdata, 64'hDEAD_0000_0000_0000);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    step(); step();

    // CSR pass-through while idle
    csr_req = 1'b1; csr_we = 1'b1; csr_addr = 12'h300; csr_wdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("pt_addr", 64'(pc_addr), 64'h300);
    check("pt_we", 64'(pc_we), 64'd1);
    check("pt_wdata", pc_wdata, 64'h1234_5678_9ABC_DEF0);
    check("pt_rdata", csr_rdata, 64'hDEAD_0000_0000_0300);
    csr_req = 1'b0;
    #1;
    check("idle_pc_addr", 64'(pc_addr), 64'd0);
    check("idle_pc_we", 64'(pc_we), 64'd0);
    csr_we = 1'b0;
    step();

    // Periodic sampling, period 100
    cfg_en = 1'b1;
    wait_busy(120, n);
    check("first_tick", 64'(n), 64'd100);
    clear_q();
    run_record(64'd0, 0, 12'hFFF, 0, dur);
    check("rec1_dur", 64'(dur), 64'd14);
    check_record(64'd1);
    check("seq1", 64'(seq), 64'd1);

    // Backpressure on the third counter word
    wait_busy(120, n);
    check("period2", 64'(n), 64'd86);
    clear_q();
    run_record(64'h18, 5, 12'hFFF, 0, dur);
    check("rec2_dur", 64'(dur), 64'd19);
    check_record(64'd2);
    check("seq2", 64'(seq), 64'd2);

    // CSR holds the port for 3 cycles while the engine is in READ k=2
    wait_busy(120, n);
    check("period3", 64'(n), 64'd81);
    clear_q();
    run_record(64'd0, 0, 12'hB05, 3, dur);
    check("rec3_dur", 64'(dur), 64'd17);
    check_record(64'd3);
    check("seq3", 64'(seq), 64'd3);

    // Overrun with period 5
    cfg_en = 1'b0; cfg_period = 32'd5;
    step(); step();
    cfg_en = 1'b1;
    wait_busy(20, n);
    check("ov_first", 64'(n), 64'd5);
    for (int i = 0; i < 16; i++) begin
      bz[i] = busy;
      ov[i] = overrun;
      if (i < 15) step();
    end
    clear_q();
    cnt = 0;
    for (int i = 0; i < 16; i++) cnt += int'(ov[i]);
    check("ov_pulse_pos", 64'(ov[10]), 64'd1);
    check("ov_pulse_cnt", 64'(cnt), 64'd1);
    check("ov_busy_13", 64'(bz[13]), 64'd1);
    check("ov_busy_gap", 64'(bz[14]), 64'd0);
    check("ov_pending_start", 64'(bz[15]), 64'd1);
    check("ov_seq", 64'(seq), 64'd4);

    // Disable mid-record: record finishes, pending is discarded
    repeat (6) step();
    cfg_en = 1'b0;
    n = 0;
    while (busy && n < 30) begin
      step();
      n++;
    end
    check("dis_finish", 64'(n), 64'd8);
    check_record(64'd5);
    check("dis_seq", 64'(seq), 64'd5);
    cfg_period = 32'd0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(busy); end
    cfg_en = 1'b1;
    for (int i = 0; i < 10; i++) begin step(); cnt += int'(busy); end
    check("dis_no_pending", 64'(cnt), 64'd0);

    // IRQ rising edge, held high 50 cycles
    clear_q();
    irq = 1'b1;
    rises = 0;
    prev = busy;
    for (int i = 0; i < 60; i++) begin
      if (i == 50) irq = 1'b0;
      step();
      if (busy && !prev) rises++;
      prev = busy;
    end
    check("irq_rises", 64'(rises), 64'd1);
    check_record(64'd6);
    check("irq_seq", 64'(seq), 64'd6);

    // Asynchronous reset in the middle of SEND
    irq = 1'b1;
    n = 0;
    while (!(smp_valid && smp_addr == BASE + 64'h10) && n < 30) begin
      step();
      n++;
    end
    check("midsend_found", 64'(smp_valid && smp_addr == BASE + 64'h10), 64'd1);
    #1 rst_ni = 1'b0;
    irq = 1'b0;
    #1;
    check("ar_valid", 64'(smp_valid), 64'd0);
    check("ar_busy", 64'(busy), 64'd0);
    check("ar_seq", 64'(seq), 64'd0);
    check("ar_addr", smp_addr, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    clear_q();
    cnt = 0;
    for (int i = 0; i < 30; i++) begin step(); cnt += int'(busy); end
    check("ar_no_resume", 64'(cnt), 64'd0);
    check("ar_no_words", 64'(q_addr.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
